// File: rtl/frmpool_pkg.sv
// -----------------------------------------------------------------------------
// frmpool_pkg
// Shared definitions for the frame-pool arbiter:
//   - requester ID encoding for the two read ports (also used as the read tag)
//   - default address/data widths of the frame-pool SRAM wrapper
//   - width of the write-streak counter
// -----------------------------------------------------------------------------
package frmpool_pkg;

    localparam int FRMPOOL_ADDR_W = 6;
    localparam int FRMPOOL_DATA_W = 28;

    // Wide enough for any legal WR_STREAK_MAX (1..15).
    localparam int STREAK_W = 4;

    typedef enum logic {
        REQ_RD0 = 1'b0,
        REQ_RD1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/frmpool_rr_arb2.sv
// -----------------------------------------------------------------------------
// frmpool_rr_arb2
// Two-input round-robin picker for the read requesters.
// Ports:
//   req_i      [1:0]  request bits, one per reader
//   ptr_i             preferred reader this cycle
//   en_i              picker may grant this cycle (low when a write wins)
//   gnt_o      [1:0]  one-hot grant, all zero when nothing is granted
//   ptr_next_o        pointer for the next cycle
// -----------------------------------------------------------------------------
module frmpool_rr_arb2
    import frmpool_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output req_id_e    ptr_next_o
);

    req_id_e other;

    assign other = (ptr_i == REQ_RD0) ? REQ_RD1 : REQ_RD0;

    // After a grant the pointer names the reader that was not served, so a
    // lone requester cannot lock out the other one once it starts asking.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        gnt_o      = 2'b00;
        ptr_next_o = ptr_i;
        if (en_i) begin
            if (req_i[ptr_i]) begin
                gnt_o[ptr_i] = 1'b1;
                ptr_next_o   = other;
            end else if (req_i[other]) begin
                gnt_o[other] = 1'b1;
                ptr_next_o   = ptr_i;
            end
        end
    end

endmodule

// File: rtl/frmpool_arb.sv
// -----------------------------------------------------------------------------
// frmpool_arb
// Arbiter/sequencer in front of the single-port frame-pool SRAM wrapper.
// One write requester and two read requesters share the SRAM; at most one
// operation is issued per cycle. Writes win until they have been granted
// WR_STREAK_MAX times in a row with a read waiting, then a read is served.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data  write request channel
//   rd_valid/rd_ready [1:0], rd_addr    read request channels (packed addrs)
//   rsp_valid [1:0], rsp_data         read response, one cycle wide
//   ram_read_en, ram_write_en,
//   ram_addr_r, ram_addr_w,
//   ram_data_in                       registered SRAM command
//   ram_data_out                      SRAM read data (cycle after read_en)
//   busy                              command or response in flight
// Timing: handshake in T, SRAM command in T+1, read response in T+2.
// -----------------------------------------------------------------------------
module frmpool_arb
    import frmpool_pkg::*;
#(
    parameter int ADDR_W        = FRMPOOL_ADDR_W,
    parameter int DATA_W        = FRMPOOL_DATA_W,
    parameter int WR_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,

    input  logic [1:0]          rd_valid,
    output logic [1:0]          rd_ready,
    input  logic [2*ADDR_W-1:0] rd_addr,

    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,

    output logic                ram_read_en,
    output logic                ram_write_en,
    output logic [ADDR_W-1:0]   ram_addr_r,
    output logic [ADDR_W-1:0]   ram_addr_w,
    output logic [DATA_W-1:0]   ram_data_in,
    input  logic [DATA_W-1:0]   ram_data_out,

    output logic                busy
);

    // ---------------- arbitration ----------------
    logic                any_rd;
    logic                wr_gnt;
    logic [1:0]          rd_gnt;
    logic                rd_gnt_any;
    req_id_e             rd_tag;
    logic [ADDR_W-1:0]   rd_gnt_addr;

    req_id_e             rr_q, rr_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    assign any_rd = |rd_valid;

    // The streak limit only matters when a read is actually waiting.
    assign wr_gnt = wr_valid &&
                    ((streak_q < STREAK_W'(WR_STREAK_MAX)) || !any_rd);

    frmpool_rr_arb2 u_rr_arb2 (
        .req_i      (rd_valid),
        .ptr_i      (rr_q),
        .en_i       (!wr_gnt),
        .gnt_o      (rd_gnt),
        .ptr_next_o (rr_d)
    );

    assign wr_ready    = wr_gnt;
    assign rd_ready    = rd_gnt;
    assign rd_gnt_any  = |rd_gnt;
    assign rd_tag      = rd_gnt[1] ? REQ_RD1 : REQ_RD0;
    assign rd_gnt_addr = rd_gnt[1] ? rd_addr[ADDR_W +: ADDR_W]
                                   : rd_addr[0 +: ADDR_W];

    always_comb begin
        streak_d = streak_q;
        if (!any_rd || rd_gnt_any) begin
            streak_d = '0;
        end else if (wr_gnt) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // ---------------- command and response pipeline ----------------
    logic              ram_read_en_q, ram_write_en_q;
    logic [ADDR_W-1:0] ram_addr_r_q, ram_addr_w_q;
    logic [DATA_W-1:0] ram_data_in_q;
    req_id_e           tag_q;        // reader owning the command in flight
    logic              rsp_pending_q;
    req_id_e           rsp_tag_q;    // reader owning the data arriving now
    logic [DATA_W-1:0] rsp_hold_q;   // last delivered response word

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q           <= REQ_RD0;
            streak_q       <= '0;
            ram_read_en_q  <= 1'b0;
            ram_write_en_q <= 1'b0;
            ram_addr_r_q   <= '0;
            ram_addr_w_q   <= '0;
            ram_data_in_q  <= '0;
            tag_q          <= REQ_RD0;
            rsp_pending_q  <= 1'b0;
            rsp_tag_q      <= REQ_RD0;
            rsp_hold_q     <= '0;
        end else begin
            rr_q           <= rr_d;
            streak_q       <= streak_d;
            ram_write_en_q <= wr_gnt;
            ram_read_en_q  <= rd_gnt_any;
            if (wr_gnt) begin
                ram_addr_w_q  <= wr_addr;
                ram_data_in_q <= wr_data;
            end
            if (rd_gnt_any) begin
                ram_addr_r_q <= rd_gnt_addr;
                tag_q        <= rd_tag;
            end
            rsp_pending_q <= ram_read_en_q;
            rsp_tag_q     <= tag_q;
            if (rsp_pending_q) begin
                rsp_hold_q <= ram_data_out;
            end
        end
    end

    assign ram_read_en  = ram_read_en_q;
    assign ram_write_en = ram_write_en_q;
    assign ram_addr_r   = ram_addr_r_q;
    assign ram_addr_w   = ram_addr_w_q;
    assign ram_data_in  = ram_data_in_q;

    // SRAM data is only meaningful in the response cycle; otherwise replay
    // the last delivered word so rsp_data stays stable between responses.
    assign rsp_valid = !rsp_pending_q       ? 2'b00 :
                       (rsp_tag_q == REQ_RD1) ? 2'b10 : 2'b01;
    assign rsp_data  = rsp_pending_q ? ram_data_out : rsp_hold_q;

    assign busy = ram_read_en_q | ram_write_en_q | rsp_pending_q;

endmodule

// File: tb/tb_frmpool_arb.sv
`timescale 1ns/1ps
module tb_frmpool_arb;
    import frmpool_pkg::*;

    localparam int ADDR_W        = 6;
    localparam int DATA_W        = 28;
    localparam int WR_STREAK_MAX = 4;
    localparam int DEPTH         = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr = '0;
    logic [DATA_W-1:0]   wr_data = '0;
    logic [1:0]          rd_valid = 2'b00;
    logic [1:0]          rd_ready;
    logic [2*ADDR_W-1:0] rd_addr = '0;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                ram_read_en, ram_write_en;
    logic [ADDR_W-1:0]   ram_addr_r, ram_addr_w;
    logic [DATA_W-1:0]   ram_data_in;
    logic [DATA_W-1:0]   ram_data_out;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frmpool_arb #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .WR_STREAK_MAX (WR_STREAK_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_addr_r   (ram_addr_r),
        .ram_addr_w   (ram_addr_w),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .busy         (busy)
    );

    // SRAM wrapper model: registered read; output is junk when not reading.
    logic [DATA_W-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) sram[ram_addr_w] <= ram_data_in;
        if (ram_read_en) ram_data_out <= sram[ram_addr_r];
        else             ram_data_out <= DATA_W'($urandom);
    end

    // ---------------- reference model ----------------
    // Memory in issue order, arbitration rules, and a queue of responses
    // due a fixed number of cycles after each read handshake.
    typedef struct {
        int                due;
        logic              port;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] model_mem [DEPTH];
    rsp_t              exp_q[$];
    int                m_streak = 0;
    int                m_rr     = 0;
    int                cyc      = 0;
    logic [DATA_W-1:0] m_last   = '0;
    bit                m_cmd_prev = 1'b0;

    always @(negedge clk) begin : monitor
        logic              any_rd;
        logic              exp_wr;
        logic [1:0]        exp_rd;
        logic [1:0]        exp_rsp;
        logic [DATA_W-1:0] exp_data;
        logic              exp_busy;
        int                pick;
        if (!rst_n) begin
            m_streak   = 0;
            m_rr       = 0;
            m_last     = '0;
            m_cmd_prev = 1'b0;
            exp_q.delete();
        end else begin
            any_rd = |rd_valid;
            exp_wr = wr_valid && ((m_streak < WR_STREAK_MAX) || !any_rd);
            exp_rd = 2'b00;
            pick   = -1;
            if (!exp_wr && any_rd) begin
                pick = rd_valid[m_rr] ? m_rr : 1 - m_rr;
                exp_rd[pick] = 1'b1;
            end
            exp_rsp  = 2'b00;
            exp_data = m_last;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_rsp  = exp_q[0].port ? 2'b10 : 2'b01;
                exp_data = exp_q[0].data;
                m_last   = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            exp_busy = m_cmd_prev || (exp_rsp != 2'b00);

            checks++;
            if ({wr_ready, rd_ready} !== {exp_wr, exp_rd}) begin
                failures++;
                $display("FAIL mon_ready cyc=%0d: got wr=%b rd=%b, want wr=%b rd=%b",
                         cyc, wr_ready, rd_ready, exp_wr, exp_rd);
            end
            checks++;
            if (ram_read_en && ram_write_en) begin
                failures++;
                $display("FAIL mon_en_excl cyc=%0d: read_en and write_en both 1", cyc);
            end
            checks++;
            if (rsp_valid !== exp_rsp || rsp_data !== exp_data) begin
                failures++;
                $display("FAIL mon_rsp cyc=%0d: got %b/%h, want %b/%h",
                         cyc, rsp_valid, rsp_data, exp_rsp, exp_data);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL mon_busy cyc=%0d: got %b, want %b", cyc, busy, exp_busy);
            end

            if (exp_wr) model_mem[wr_addr] = wr_data;
            if (pick >= 0) begin
                exp_q.push_back('{due: cyc + 2, port: pick[0],
                                  data: model_mem[rd_addr[pick*ADDR_W +: ADDR_W]]});
                m_rr = 1 - pick;
            end
            if (!any_rd || pick >= 0) m_streak = 0;
            else if (exp_wr)          m_streak++;
            m_cmd_prev = exp_wr || (pick >= 0);
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit done = 1'b0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = wr_ready;
            next_cycle();
        end
        wr_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL write_accept: addr %0d not accepted within 20 cycles", a);
        end
    endtask

    // Returns one cycle after the handshake (the SRAM command cycle).
    task automatic do_read(input int p, input logic [ADDR_W-1:0] a);
        bit done = 1'b0;
        rd_addr[p*ADDR_W +: ADDR_W] = a;
        rd_valid[p] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = rd_ready[p];
            next_cycle();
        end
        rd_valid[p] = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL read_accept: port %0d addr %0d not accepted within 20 cycles", p, a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_ready, rd_ready, rsp_valid, ram_read_en, ram_write_en, busy} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, want 0",
                     {wr_ready, rd_ready, rsp_valid, ram_read_en, ram_write_en, busy});
        end
        checks++;
        if ({ram_addr_r, ram_addr_w, ram_data_in, rsp_data} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h/%h/%h, want 0",
                     ram_addr_r, ram_addr_w, ram_data_in, rsp_data);
        end
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] g [8];
        logic [1:0] want_rsp;
        logic [DATA_W-1:0] want_data;
        rd_addr  = {6'd2, 6'd1};
        rd_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g[i] = rd_ready;
            if (i >= 2) begin
                want_rsp  = (i % 2 == 0) ? 2'b01 : 2'b10;
                want_data = (i % 2 == 0) ? model_mem[1] : model_mem[2];
                checks++;
                if (rsp_valid !== want_rsp || rsp_data !== want_data) begin
                    failures++;
                    $display("FAIL rr_rsp[%0d]: got %b/%h, want %b/%h",
                             i, rsp_valid, rsp_data, want_rsp, want_data);
                end
            end
            next_cycle();
        end
        rd_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (g[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b, want %b",
                         i, g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_write_then_read();
        do_write(6'd5, 28'h0ABCDEF);
        do_read(0, 6'd5);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL wr_rd_early: rsp_valid %b one cycle after handshake, want 00", rsp_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 28'h0ABCDEF) begin
            failures++;
            $display("FAIL wr_rd_rsp: got %b/%h, want 01/0abcdef", rsp_valid, rsp_data);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_same_cycle();
        wr_addr  = 6'd9;
        wr_data  = 28'h1234567;
        wr_valid = 1'b1;
        rd_addr[0 +: ADDR_W] = 6'd9;
        rd_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || rd_ready !== 2'b00) begin
            failures++;
            $display("FAIL same_first: got wr=%b rd=%b, want wr=1 rd=00", wr_ready, rd_ready);
        end
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_ready !== 2'b01) begin
            failures++;
            $display("FAIL same_second: rd_ready %b, want 01", rd_ready);
        end
        next_cycle();
        rd_valid = 2'b00;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 28'h1234567) begin
            failures++;
            $display("FAIL same_rsp: got %b/%h, want 01/1234567", rsp_valid, rsp_data);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_write_streak();
        bit w;
        logic [1:0] r;
        bit want_read;
        rd_addr[ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
        rd_valid = 2'b10;
        wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
        wr_data  = DATA_W'($urandom);
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            w = wr_ready;
            r = rd_ready;
            want_read = (i == WR_STREAK_MAX) || (i == 2 * WR_STREAK_MAX + 1);
            checks++;
            if (w !== !want_read || r !== (want_read ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL streak[%0d]: got wr=%b rd=%b, want %s",
                         i, w, r, want_read ? "read" : "write");
            end
            next_cycle();
            if (w) begin
                wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                wr_data = DATA_W'($urandom);
            end
        end
        wr_valid = 1'b0;
        rd_valid = 2'b00;
        repeat (3) next_cycle();
    endtask

    task automatic test_idle();
        wr_valid = 1'b0;
        rd_valid = 2'b00;
        repeat (3) next_cycle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_ready, rd_ready, ram_read_en, ram_write_en, busy} !== 6'd0
                || rsp_data !== m_last) begin
                failures++;
                $display("FAIL idle[%0d]: ctrl %b data %h, want 0 and %h", i,
                         {wr_ready, rd_ready, ram_read_en, ram_write_en, busy}, rsp_data, m_last);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        bit acc_w;
        logic [1:0] acc_r;
        for (int c = 0; c < 400; c++) begin
            if (!wr_valid && $urandom_range(0, 2) != 0) begin
                wr_valid = 1'b1;
                wr_addr  = ADDR_W'($urandom_range(0, 7));
                wr_data  = DATA_W'($urandom);
            end
            for (int p = 0; p < 2; p++) begin
                if (!rd_valid[p] && $urandom_range(0, 1) == 1) begin
                    rd_valid[p] = 1'b1;
                    rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
                end
            end
            @(negedge clk);
            acc_w = wr_ready;
            acc_r = rd_ready;
            next_cycle();
            if (acc_w) wr_valid = 1'b0;
            rd_valid = rd_valid & ~acc_r;
        end
        wr_valid = 1'b0;
        rd_valid = 2'b00;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_midop();
        do_read(1, 6'd7);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_ready, rd_ready, rsp_valid, ram_read_en, ram_write_en, busy} !== 8'd0
            || {ram_addr_r, ram_addr_w, ram_data_in, rsp_data} !== '0) begin
            failures++;
            $display("FAIL midop_reset: ctrl %b addr_r %h addr_w %h din %h rsp %h, want all 0",
                     {wr_ready, rd_ready, rsp_valid, ram_read_en, ram_write_en, busy},
                     ram_addr_r, ram_addr_w, ram_data_in, rsp_data);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midop_after[%0d]: rsp_valid %b busy %b, want 00/0", i, rsp_valid, busy);
            end
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] v;
            v = DATA_W'($urandom);
            sram[i]      <= v;
            model_mem[i] = v;
        end
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_same_cycle();
        test_write_streak();
        test_idle();
        test_random();
        test_reset_midop();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
